// File: rtl/ram_wr_scheduler_pkg.sv
// Shared types for the RAM write scheduler: FSM encoding and the round-robin
// index helper used by the arbiter.
package ram_wr_scheduler_pkg;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } sched_state_t;

  // Index visited k steps after base, wrapping at n (n need not be a power of two).
  function automatic int rr_next(input int base, input int k, input int n);
    return (base + k) % n;
  endfunction

endpackage

// File: rtl/ram_wr_scheduler_rr_arbiter.sv
// Round-robin grant: search starts just after ptr, first valid requester wins.
// Produces a one-hot grant and the winner index.
module rr_arbiter
  import ram_wr_scheduler_pkg::*;
#(
  parameter int NR = 4,
  parameter int IW = $clog2(NR)
) (
  input  logic [NR-1:0] vld,
  input  logic [IW-1:0] ptr,
  output logic [NR-1:0] gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= NR; k++) begin
      j = rr_next(int'(ptr), k, NR);
      if (!any && vld[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/ram_wr_scheduler.sv
// Write-port scheduler for a two-port RAM: round-robin among NR requesters with
// one registered output stage, plus a full-depth clear sweep writing CLR_VAL.
module ram_wr_scheduler
  import ram_wr_scheduler_pkg::*;
#(
  parameter int             NR      = 4,
  parameter int             DW      = 8,
  parameter int             MD      = 1024,
  parameter int             AW      = $clog2(MD),
  parameter int             IW      = $clog2(NR),
  parameter logic [DW-1:0]  CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  output logic             clr_busy,
  output logic             clr_done,
  input  logic [NR-1:0]    req_vld,
  input  logic [NR*AW-1:0] req_adr,
  input  logic [NR*DW-1:0] req_dat,
  output logic [NR-1:0]    req_rdy,
  output logic             mem_we,
  output logic [AW-1:0]    mem_adr,
  output logic [DW-1:0]    mem_dat,
  output logic [IW-1:0]    mem_id
);

  localparam logic [AW-1:0] LAST_ADR = AW'(MD - 1);

  sched_state_t state_q, state_d;
  logic [IW-1:0] ptr;
  logic [AW-1:0] cnt;
  logic [NR-1:0] gnt;
  logic [IW-1:0] win;
  logic          any;
  logic          accept;

  logic [AW-1:0] adr_a [NR];
  logic [DW-1:0] dat_a [NR];

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      adr_a[i] = req_adr[i*AW +: AW];
      dat_a[i] = req_dat[i*DW +: DW];
    end
  end

  rr_arbiter #(.NR(NR), .IW(IW)) u_arb (
    .vld (req_vld),
    .ptr (ptr),
    .gnt (gnt),
    .idx (win),
    .any (any)
  );

  assign req_rdy = (state_q == ST_ARB) ? gnt : '0;
  assign accept  = (state_q == ST_ARB) && any;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_ARB;
    else     state_q <= state_d;
  end

  // clr_busy doubles as the "sweep has started" flag: the first CLEAR cycle is
  // left free so a write accepted on the ARB->CLEAR edge drains before address 0.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARB:   if (clr) state_d = ST_CLEAR;
      ST_CLEAR: if (clr_busy && cnt == LAST_ADR) state_d = ST_ARB;
      default:  state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= IW'(NR - 1);
      cnt      <= '0;
      mem_we   <= 1'b0;
      mem_adr  <= '0;
      mem_dat  <= '0;
      mem_id   <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (state_q)
        ST_ARB: begin
          mem_we <= accept;
          if (accept) begin
            mem_adr <= adr_a[win];
            mem_dat <= dat_a[win];
            mem_id  <= win;
            ptr     <= win;
          end
        end
        ST_CLEAR: begin
          if (!clr_busy) begin
            mem_we   <= 1'b1;
            mem_adr  <= '0;
            mem_dat  <= CLR_VAL;
            mem_id   <= '0;
            cnt      <= '0;
            clr_busy <= 1'b1;
          end else if (cnt == LAST_ADR) begin
            mem_we   <= 1'b0;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            cnt     <= cnt + 1'b1;
            mem_adr <= cnt + 1'b1;
          end
        end
        default: mem_we <= 1'b0;
      endcase
    end
  end

endmodule
